// File: rtl/ir_command_receiver_if.sv
// ----------------------------------------------------------------------------
// ir_command_receiver_if
// Groups the IR receiver line and the decoded-command outputs of the SIRC
// command receiver into one bundle.
//
// Signals:
//   ir_in          demodulated IR line, low = carrier burst (mark), high = space
//   command[11:0]  last valid decoded frame ([11:7] angle, [6:0] distance)
//   command_ready  one-cycle pulse, command is valid and new
//   frame_error    one-cycle pulse, a frame was aborted
//
// Modports:
//   master  the receiver itself (reads ir_in, drives the command outputs)
//   slave   the surrounding system (drives ir_in, consumes the command)
// ----------------------------------------------------------------------------
interface ir_command_receiver_if;
   logic        ir_in;
   logic [11:0] command;
   logic        command_ready;
   logic        frame_error;

   modport master (
      input  ir_in,
      output command,
      output command_ready,
      output frame_error
   );

   modport slave (
      output ir_in,
      input  command,
      input  command_ready,
      input  frame_error
   );
endinterface

// File: rtl/ir_command_receiver.sv
// ----------------------------------------------------------------------------
// ir_command_receiver
// Decodes 12-bit SIRC remote-control frames from a demodulated IR receiver.
// A frame is a start mark of about 4U, then 12 bits, each a space of about U
// followed by a mark of U (bit 0) or 2U (bit 1). Bits arrive LSB first.
//
// Parameters:
//   UNIT_CYCLES  clock cycles per 600 us base unit U (16200 at 27 MHz)
//
// Ports:
//   clock   system clock, all state changes on its rising edge
//   reset   asynchronous, active-high reset
//   bus     ir_command_receiver_if.master
//             ir_in          raw asynchronous IR line (low = mark)
//             command        last valid 12-bit frame, held between frames
//             command_ready  one-cycle pulse when command is updated
//             frame_error    one-cycle pulse when a frame is aborted
// ----------------------------------------------------------------------------
module ir_command_receiver #(
   parameter int UNIT_CYCLES = 16200
) (
   input logic                   clock,
   input logic                   reset,
   ir_command_receiver_if.master bus
);

   // Timing windows, all in clock cycles, derived from U by integer division.
   localparam int START_MIN_I   = 3 * UNIT_CYCLES;
   localparam int START_MAX_I   = 5 * UNIT_CYCLES;
   localparam int BIT_MIN_I     = UNIT_CYCLES / 2;
   localparam int BIT_ONE_MIN_I = (3 * UNIT_CYCLES) / 2;
   localparam int BIT_MAX_I     = (5 * UNIT_CYCLES) / 2;
   localparam int SPACE_MAX_I   = 2 * UNIT_CYCLES;

   // The counter is wide enough that it can never saturate before the
   // longest legal interval (the start mark) has timed out.
   localparam int CNT_W = $clog2(START_MAX_I + 2) + 1;
   localparam int LEN_W = CNT_W + 1;

   localparam logic [LEN_W-1:0] START_MIN   = LEN_W'(START_MIN_I);
   localparam logic [LEN_W-1:0] START_MAX   = LEN_W'(START_MAX_I);
   localparam logic [LEN_W-1:0] BIT_MIN     = LEN_W'(BIT_MIN_I);
   localparam logic [LEN_W-1:0] BIT_ONE_MIN = LEN_W'(BIT_ONE_MIN_I);
   localparam logic [LEN_W-1:0] BIT_MAX     = LEN_W'(BIT_MAX_I);
   localparam logic [LEN_W-1:0] SPACE_MAX   = LEN_W'(SPACE_MAX_I);

   typedef enum logic [1:0] {
      IDLE,
      START_MARK,
      SPACE,
      BIT_MARK
   } state_t;

   state_t            state;
   logic              sync_meta;
   logic              ir_sync;
   logic              ir_prev;
   logic [1:0]        settle;
   logic [CNT_W-1:0]  count;
   logic [3:0]        bit_index;
   logic [11:0]       shift_reg;
   logic [11:0]       command_q;
   logic              ready_q;
   logic              error_q;

   logic              settled;
   logic              is_fall;
   logic              is_rise;
   logic [LEN_W-1:0]  edge_len;
   logic [LEN_W-1:0]  run_len;
   logic              bit_value;
   logic [11:0]       shifted;

   // The synchronizer and edge flops come out of reset at 1, which is not a
   // real observation of the line. Edges are trusted only once three genuine
   // samples have flowed through, so a line already low at reset release
   // cannot look like a fresh falling edge.
   assign settled  = (settle == 2'd3);
   assign is_fall  = settled & ir_prev & ~ir_sync;
   assign is_rise  = settled & ~ir_prev & ir_sync;

   // The counter is zeroed in the cycle of an edge and counts up afterwards,
   // so when the next edge arrives it holds (length - 1); while the level is
   // still running, the cycles seen so far including the current one is
   // count + 2.
   assign edge_len  = {1'b0, count} + LEN_W'(1);
   assign run_len   = {1'b0, count} + LEN_W'(2);
   assign bit_value = (edge_len >= BIT_ONE_MIN);
   assign shifted   = {bit_value, shift_reg[11:1]};

   assign bus.command       = command_q;
   assign bus.command_ready = ready_q;
   assign bus.frame_error   = error_q;

   // Synchronizer, interval counter and frame decoder. Every abort path
   // clears the partial frame and returns to IDLE without touching command,
   // so a broken frame never disturbs the last good one. The outputs are
   // registered pulses that default low each cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sync_meta <= 1'b1;
         ir_sync   <= 1'b1;
         ir_prev   <= 1'b1;
         settle    <= 2'd0;
         count     <= '0;
         bit_index <= 4'd0;
         shift_reg <= 12'h000;
         command_q <= 12'h000;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         sync_meta <= bus.ir_in;
         ir_sync   <= sync_meta;
         ir_prev   <= ir_sync;

         if (!settled) begin
            settle <= settle + 2'd1;
         end

         if (ir_sync != ir_prev) begin
            count <= '0;
         end else if (count != '1) begin
            count <= count + CNT_W'(1);
         end

         ready_q <= 1'b0;
         error_q <= 1'b0;

         case (state)
            IDLE: begin
               if (is_fall) begin
                  state <= START_MARK;
               end
            end

            START_MARK: begin
               if (is_rise) begin
                  if (edge_len >= START_MIN && edge_len <= START_MAX) begin
                     state     <= SPACE;
                     bit_index <= 4'd0;
                     shift_reg <= 12'h000;
                  end else begin
                     error_q   <= 1'b1;
                     shift_reg <= 12'h000;
                     bit_index <= 4'd0;
                     state     <= IDLE;
                  end
               end else if (!ir_sync && run_len > START_MAX) begin
                  error_q   <= 1'b1;
                  shift_reg <= 12'h000;
                  bit_index <= 4'd0;
                  state     <= IDLE;
               end
            end

            SPACE: begin
               if (is_fall) begin
                  if (edge_len <= SPACE_MAX) begin
                     state <= BIT_MARK;
                  end else begin
                     error_q   <= 1'b1;
                     shift_reg <= 12'h000;
                     bit_index <= 4'd0;
                     state     <= IDLE;
                  end
               end else if (ir_sync && run_len > SPACE_MAX) begin
                  error_q   <= 1'b1;
                  shift_reg <= 12'h000;
                  bit_index <= 4'd0;
                  state     <= IDLE;
               end
            end

            BIT_MARK: begin
               if (is_rise) begin
                  if (edge_len < BIT_MIN) begin
                     error_q   <= 1'b1;
                     shift_reg <= 12'h000;
                     bit_index <= 4'd0;
                     state     <= IDLE;
                  end else if (bit_index == 4'd11) begin
                     command_q <= shifted;
                     ready_q   <= 1'b1;
                     shift_reg <= 12'h000;
                     bit_index <= 4'd0;
                     state     <= IDLE;
                  end else begin
                     shift_reg <= shifted;
                     bit_index <= bit_index + 4'd1;
                     state     <= SPACE;
                  end
               end else if (!ir_sync && run_len > BIT_MAX) begin
                  error_q   <= 1'b1;
                  shift_reg <= 12'h000;
                  bit_index <= 4'd0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ir_command_receiver.md
IR_COMMAND_RECEIVER -- requirements
Module: ir_command_receiver

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 16200, meaning clock cycles per 600 us SIRC base unit U (27 MHz clock).
REQ-002 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ir_in  input  1  demodulated IR receiver output, asynchronous; low = carrier burst (mark), high = space.
REQ-005 SHALL have port command  output  12  last valid decoded frame; feeds the motor command stage (bits [11:7] angle, [6:0] distance).
REQ-006 SHALL have port command_ready  output  1  one-cycle pulse; command is valid and new.
REQ-007 SHALL have port frame_error  output  1  one-cycle pulse; frame aborted.

Function
REQ-008 SHALL pass ir_in through a 2-flop synchronizer; all decoding uses the synchronized signal only.
REQ-009 SHALL measure each mark and space with one cycle counter that clears on every synchronized edge and saturates at all-ones (no wrap).
REQ-010 SHALL implement states IDLE, START_MARK, SPACE, BIT_MARK, plus a 4-bit bit index 0..11.
REQ-011 IDLE: on synchronized falling edge go to START_MARK; otherwise remain; high line has no timeout.
REQ-012 START_MARK: on rising edge, length in [3U, 5U] -> SPACE with bit index 0; length < 3U -> error.
REQ-013 START_MARK or BIT_MARK: count exceeding upper limit while still low -> error immediately, without waiting for edge.
REQ-014 SPACE: falling edge with space length <= 2U -> BIT_MARK; space count exceeding 2U -> error immediately.
REQ-015 BIT_MARK: on rising edge, length in [U/2, 3U/2) -> bit 0; [3U/2, 5U/2] -> bit 1; < U/2 -> error; upper limit 5U/2.
REQ-016 Limits SHALL use integer division of UNIT_CYCLES, computed at elaboration.
REQ-017 Bits SHALL shift into an internal 12-bit register LSB first: first received bit lands in command[0].
REQ-018 After 12th valid bit: command loads shift register, command_ready pulses one cycle, state -> IDLE; otherwise bit index increments, state -> SPACE.
REQ-019 Latency: command_ready SHALL assert exactly 3 clock cycles after the first clock edge sampling raw ir_in high at end of the 12th mark (2 sync + 1 decode).
REQ-020 Error: frame_error pulses one cycle, shift register and bit index clear, state -> IDLE, command and command_ready unchanged/low.
REQ-021 After error-mid-mark, IDLE SHALL ignore the remaining low and arm only on the next falling edge.
REQ-022 command SHALL hold its value between frames; partial frames never alter it.
REQ-023 command_ready and frame_error SHALL never assert in the same cycle.
REQ-024 Frames shorter than 12 bits followed by long space SHALL error per REQ-014.

Reset
REQ-025 On reset assertion, asynchronously: state IDLE, synchronizer flops 1, counter 0, bit index 0, shift register 0, command 12'h000, command_ready 0, frame_error 0.
REQ-026 Reset mid-frame SHALL discard the frame; no pulse on either output at release.
REQ-027 After reset release, a line already low SHALL not start a frame until a fresh falling edge.

Verification (UNIT_CYCLES=8: start 24..40, bit0 4..11, bit1 12..20, space <=16)
REQ-028 Start 32 low, then 12 bits for 12'hA5C (8 low per 0, 16 low per 1, 8 high spaces) -> command=12'hA5C, one command_ready pulse 3 cycles after final rising edge, no frame_error.
REQ-029 Start mark 16 low -> frame_error pulse at its rising edge (+3 sync/decode); command unchanged.
REQ-030 Valid start, 5 bits, line held high 40 cycles -> frame_error after space exceeds 16; subsequent valid frame 12'h001 decodes correctly.
REQ-031 Bit mark held low 30 cycles -> frame_error while line still low; no new frame until next falling edge.
REQ-032 Reset pulse during bit 6 of a frame -> all outputs reset values, no pulse; following frame 12'hFFF -> command=12'hFFF.
REQ-033 Boundary marks: bit mark 11 -> 0, 12 -> 1, 3 -> error; start 24 and 40 accepted, 41 error.
